// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the OV7670 frame capture path.
//   capture_state_t : sequencer states (IDLE, ARMED, CAPTURE)
//   DST_COLS/DST_ROWS/FRAME_WORDS : decimated 320x240 frame geometry
//   frame_words()   : decimated word count for a given source geometry
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } capture_state_t;

    localparam int DST_COLS    = 320;
    localparam int DST_ROWS    = 240;
    localparam int FRAME_WORDS = DST_COLS * DST_ROWS;

    // 2:1 decimation in both directions
    function automatic int frame_words(input int cols, input int rows);
        return (cols / 2) * (rows / 2);
    endfunction

endpackage

// File: rtl/rgb444_pack.sv
// rgb444_pack: assembles RGB444 pixels from the two-byte camera stream.
// Ports:
//   wr_clk, rst      : pixel clock, async active-high reset
//   href             : registered HREF, high while line bytes are valid
//   byte_in[7:0]     : registered camera byte
//   pix[11:0]        : {R,G,B}, valid while pix_valid is high
//   pix_valid        : high in the cycle the second byte of a pixel is present
module rgb444_pack (
    input  logic        wr_clk,
    input  logic        rst,
    input  logic        href,
    input  logic [7:0]  byte_in,
    output logic [11:0] pix,
    output logic        pix_valid
);

    logic       phase;  // 0 = expecting first byte (R), 1 = second byte (G,B)
    logic [3:0] r_q;

    // Phase snaps back to first-byte whenever href drops, so an odd
    // trailing byte on a line is simply discarded.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            r_q   <= 4'd0;
        end else if (!href) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!phase)
                r_q <= byte_in[3:0];
        end
    end

    assign pix_valid = href & phase;
    assign pix       = {r_q, byte_in};

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: OV7670 frame capture sequencer feeding a frame-buffer write port.
// Registers the camera pins, assembles RGB444 pixels, decimates 2:1 in x and y,
// and produces write address/enable. Continuous or single-shot frame sequencing.
// Ports:
//   wr_clk, rst                 : pixel clock, async active-high reset
//   cam_vsync/cam_href/cam_data : camera pins
//   continuous, snap_req        : capture mode / single-shot request
//   wraddress, data_out, wren   : frame-buffer write port
//   busy, frame_done            : status
//   err                         : sticky geometry error (only with CAPTURE_CHECK_EN)
// Build option: `define CAPTURE_CHECK_EN to build line/pixel count checking and err.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int SRC_COLS = 640,
    parameter int SRC_ROWS = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              continuous,
    input  logic              snap_req,
    output logic [ADDR_W-1:0] wraddress,
    output logic [11:0]       data_out,
    output logic              wren,
    output logic              busy,
    output logic              frame_done
`ifdef CAPTURE_CHECK_EN
    ,
    output logic              err
`endif
);

    // Extra headroom so oversized lines/frames do not wrap the counters
    localparam int XW    = $clog2(SRC_COLS) + 2;
    localparam int YW    = $clog2(SRC_ROWS) + 2;
    localparam int WORDS = frame_words(SRC_COLS, SRC_ROWS);
    localparam logic [XW-1:0]     COLS_L    = XW'(SRC_COLS);
    localparam logic [YW-1:0]     ROWS_L    = YW'(SRC_ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    // Input registers plus one delayed copy for edge detection. Reset to 0 so
    // a vsync that is already low at release is not mistaken for a falling edge.
    logic       vs_q, vs_d, hr_q, hr_d;
    logic [7:0] d_q;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
            vs_d <= 1'b0;
            hr_q <= 1'b0;
            hr_d <= 1'b0;
            d_q  <= 8'd0;
        end else begin
            vs_q <= cam_vsync;
            vs_d <= vs_q;
            hr_q <= cam_href;
            hr_d <= hr_q;
            d_q  <= cam_data;
        end
    end

    logic vs_fall, vs_rise, h_fall;
    assign vs_fall = vs_d & ~vs_q;
    assign vs_rise = vs_q & ~vs_d;
    assign h_fall  = hr_d & ~hr_q;

    logic [11:0] pix;
    logic        pix_valid;

    rgb444_pack u_pack (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .href      (hr_q),
        .byte_in   (d_q),
        .pix       (pix),
        .pix_valid (pix_valid)
    );

    capture_state_t state, state_n;
    logic           start, frame_end;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (continuous || snap_req)
                    state_n = ARMED;
            end
            ARMED: begin
                if (vs_fall) begin
                    state_n = CAPTURE;
                    start   = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_n   = continuous ? ARMED : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Pixel and line counters, live only while capturing
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (start) begin
            x <= '0;
            y <= '0;
        end else if (state == CAPTURE) begin
            if (h_fall) begin
                x <= '0;
                y <= y + 1'b1;
            end else if (pix_valid) begin
                x <= x + 1'b1;
            end
        end
    end

    // full latches once the last word is written; the wren term covers the
    // cycle where that last write is still on the output register.
    logic full, full_now, store;
    assign full_now = full | (wren & (wraddress == LAST_ADDR));
    assign store    = (state == CAPTURE) && pix_valid && !x[0] && !y[0] &&
                      (x < COLS_L) && (y < ROWS_L) && !full_now;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wraddress  <= '0;
            full       <= 1'b0;
            data_out   <= 12'd0;
            wren       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wren       <= store;
            frame_done <= frame_end;
            if (store)
                data_out <= pix;
            // address is presented with wren and advances on the following edge
            if (start) begin
                wraddress <= '0;
                full      <= 1'b0;
            end else if (wren) begin
                if (wraddress == LAST_ADDR) full      <= 1'b1;
                else                        wraddress <= wraddress + 1'b1;
            end
        end
    end

`ifdef CAPTURE_CHECK_EN
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((state == CAPTURE) &&
                 ((h_fall && (x != COLS_L)) || (vs_rise && (y != ROWS_L))))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

    localparam int C     = 16;
    localparam int R     = 8;
    localparam int AW    = 17;
    localparam int WORDS = (C / 2) * (R / 2);

    logic          wr_clk = 1'b0;
    logic          rst;
    logic          cam_vsync, cam_href, continuous, snap_req;
    logic [7:0]    cam_data;
    logic [AW-1:0] wraddress;
    logic [11:0]   data_out;
    logic          wren, busy, frame_done;
`ifdef CAPTURE_CHECK_EN
    logic          err;
`endif

    always #5 wr_clk = ~wr_clk;

    capture_ctrl #(.SRC_COLS(C), .SRC_ROWS(R), .ADDR_W(AW)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .continuous (continuous),
        .snap_req   (snap_req),
        .wraddress  (wraddress),
        .data_out   (data_out),
        .wren       (wren),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CAPTURE_CHECK_EN
        ,
        .err        (err)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic [AW+11:0] q[$];   // {wraddress, data_out} expected per write

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outputs sampled at negedge; inputs change at posedge+1.
    task automatic tick();
        logic [AW+11:0] e;
        @(negedge wr_clk);
        if (!rst) begin
            if (wren) begin
                if (q.size() == 0) begin
                    chk("unexpected_wren", {3'b0, wraddress, data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("write_addr", 32'(wraddress), 32'(e[AW+11:12]));
                    chk("write_data", 32'(data_out), 32'(e[11:0]));
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("done_before_last_write", q.size(), 0);
            end
        end
        @(posedge wr_clk);
        #1;
    endtask

    // One camera frame. px pixels per line (2 bytes each), line 0 shortened to
    // short_b bytes when nonzero. cap: frame expected to be captured from start.
    task automatic send_frame(input int px, input int lines, input int short_b, input bit cap,
                              input int clr_line, input int rst_line, input int snap_line,
                              input bit exp_busy);
        int addr, fd0, nb, p;
        bit cap_now;
        addr = 0; fd0 = fd_cnt; cap_now = cap;
        cam_vsync = 1'b0; cam_href = 1'b0;
        repeat (4) tick();
        for (int y = 0; y < lines; y++) begin
            if (y == clr_line) continuous = 1'b0;
            if (y == snap_line) begin snap_req = 1'b1; tick(); snap_req = 1'b0; end
            nb = (y == 0 && short_b > 0) ? short_b : 2 * px;
            for (int bi = 0; bi < nb; bi++) begin
                p = bi / 2;
                if (y == rst_line && bi == 8) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_wren", 32'(wren), 0);
                    chk("rst_wraddress", 32'(wraddress), 0);
                    chk("rst_busy", 32'(busy), 0);
                    q.delete();
                    cap_now = 1'b0;
                    addr = 0;
                end
                if (y == rst_line && bi == 12) rst = 1'b0;
                if (bi % 2 == 0) begin
                    cam_data = {4'($urandom), 4'(p)};
                end else begin
                    cam_data = 8'(y);
                    if (cap_now && p % 2 == 0 && y % 2 == 0 && p < C && y < R && addr < WORDS) begin
                        q.push_back({AW'(addr), 4'(p), 8'(y)});
                        addr++;
                    end
                end
                cam_href = 1'b1;
                tick();
            end
            cam_href = 1'b0;
            cam_data = 8'($urandom);
            repeat (4) tick();
        end
        cam_vsync = 1'b1;
        repeat (8) tick();
        chk("pending_writes", q.size(), 0);
        chk("frame_done_count", fd_cnt - fd0, (cap && rst_line < 0) ? 1 : 0);
        chk("busy_after_frame", 32'(busy), 32'(exp_busy));
        if (cap)
            chk("final_wraddress", 32'(wraddress), (addr >= WORDS) ? WORDS - 1 : addr);
    endtask

    typedef struct {
        bit cont;
        int px;
        int lines;
        int short_b;
        bit exp_busy;
        bit exp_err;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{1'b1, C,     R,     0, 1'b1, 1'b0};  // full frame
        vt[1] = '{1'b1, C,     R,     0, 1'b1, 1'b0};  // back-to-back full frame
        vt[2] = '{1'b1, C,     R,     5, 1'b1, 1'b1};  // odd dangling byte on line 0
        vt[3] = '{1'b1, C + 4, R + 2, 0, 1'b1, 1'b1};  // oversized frame, saturation

        rst = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'd0;
        continuous = 1'b0; snap_req = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;
        chk("reset_wraddress", 32'(wraddress), 0);
        chk("reset_data_out", 32'(data_out), 0);
        chk("reset_wren", 32'(wren), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
`ifdef CAPTURE_CHECK_EN
        chk("reset_err", 32'(err), 0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_not_busy", 32'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            continuous = vt[i].cont;
            tick();
            send_frame(vt[i].px, vt[i].lines, vt[i].short_b, 1'b1, -1, -1, -1, vt[i].exp_busy);
`ifdef CAPTURE_CHECK_EN
            chk("err_flag", 32'(err), 32'(vt[i].exp_err));
`endif
        end

        // continuous dropped mid-frame: frame completes, then idle
        send_frame(C, R, 0, 1'b1, 4, -1, -1, 1'b0);
        send_frame(C, R, 0, 1'b0, -1, -1, -1, 1'b0);

        // single shot, with a stray snap_req while capturing
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        tick();
        chk("snap_armed_busy", 32'(busy), 1);
        send_frame(C, R, 0, 1'b1, -1, -1, 3, 1'b0);
        send_frame(C, R, 0, 1'b0, -1, -1, -1, 1'b0);
        send_frame(C, R, 0, 1'b0, -1, -1, -1, 1'b0);

        // reset mid-frame, then a clean frame from address 0
        continuous = 1'b1;
        tick();
        send_frame(C, R, 0, 1'b1, -1, 4, -1, 1'b1);
        send_frame(C, R, 0, 1'b1, -1, -1, -1, 1'b1);
`ifdef CAPTURE_CHECK_EN
        chk("err_after_reset", 32'(err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
